// File: rtl/householder_apply.sv
// R = H*A for 2x2 signed Q8.8 matrices using one shared 16x16 multiplier
// stepped over eight products; results are published together with a done pulse.
module householder_apply (
  input  logic        I_sys_clk,
  input  logic        I_sys_rstn,
  input  logic        I_start,
  input  logic [15:0] I_H1_h11,
  input  logic [15:0] I_H1_h12,
  input  logic [15:0] I_H1_h21,
  input  logic [15:0] I_H1_h22,
  input  logic [15:0] I_a11,
  input  logic [15:0] I_a12,
  input  logic [15:0] I_a21,
  input  logic [15:0] I_a22,
  output logic        O_busy,
  output logic        O_done,
  output logic [15:0] O_r11,
  output logic [15:0] O_r12,
  output logic [15:0] O_r21,
  output logic [15:0] O_r22
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [2:0]         idx_r;
  logic signed [31:0] acc_r;
  logic signed [15:0] h_r [4];      // h11, h12, h21, h22
  logic signed [15:0] a_r [4];      // a11, a12, a21, a22
  logic [15:0]        shadow_r [4]; // r11, r12, r21, r22

  logic signed [15:0] mul_h_s;
  logic signed [15:0] mul_a_s;
  logic signed [31:0] prod_s;
  logic signed [33:0] sum_s;
  logic [15:0]        res_s;

  // Round half toward +inf from Q16.16 to Q8.8, then clamp to the 16-bit range.
  function automatic logic [15:0] round_sat(input logic signed [33:0] sum);
    logic signed [33:0] shifted;
    shifted = (sum + 34'sd128) >>> 8;
    if (shifted > 34'sd32767) begin
      return 16'h7FFF;
    end else if (shifted < -34'sd32768) begin
      return 16'h8000;
    end else begin
      return shifted[15:0];
    end
  endfunction

  // Operand selection: idx[2] picks the H row, idx[0] the inner index, idx[1] the A column.
  always_comb begin
    mul_h_s = h_r[{idx_r[2], idx_r[0]}];
    mul_a_s = a_r[{idx_r[0], idx_r[1]}];
    prod_s  = mul_h_s * mul_a_s;
    sum_s   = {{2{acc_r[31]}}, acc_r} + {{2{prod_s[31]}}, prod_s};
    res_s   = round_sat(sum_s);
  end

  // Control FSM, operand capture, accumulation and output publication.
  always_ff @(posedge I_sys_clk) begin
    if (!I_sys_rstn) begin
      state_r <= ST_IDLE;
      idx_r   <= 3'd0;
      acc_r   <= 32'sd0;
      for (int i = 0; i < 4; i++) begin
        h_r[i]      <= 16'sd0;
        a_r[i]      <= 16'sd0;
        shadow_r[i] <= 16'h0000;
      end
      O_busy <= 1'b0;
      O_done <= 1'b0;
      O_r11  <= 16'h0000;
      O_r12  <= 16'h0000;
      O_r21  <= 16'h0000;
      O_r22  <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          O_done <= 1'b0;
          idx_r  <= 3'd0;
          acc_r  <= 32'sd0;
          if (I_start) begin
            h_r[0]  <= I_H1_h11;
            h_r[1]  <= I_H1_h12;
            h_r[2]  <= I_H1_h21;
            h_r[3]  <= I_H1_h22;
            a_r[0]  <= I_a11;
            a_r[1]  <= I_a12;
            a_r[2]  <= I_a21;
            a_r[3]  <= I_a22;
            O_busy  <= 1'b1;
            state_r <= ST_MAC;
          end else begin
            O_busy <= 1'b0;
          end
        end
        ST_MAC: begin
          if (!idx_r[0]) begin
            acc_r <= prod_s;
          end else begin
            shadow_r[idx_r[2:1]] <= res_s;
          end
          idx_r <= idx_r + 3'd1;
          if (idx_r == 3'd7) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_MAC;
          end
        end
        ST_DONE: begin
          O_r11   <= shadow_r[0];
          O_r12   <= shadow_r[1];
          O_r21   <= shadow_r[2];
          O_r22   <= shadow_r[3];
          O_done  <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          O_busy  <= 1'b0;
          O_done  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_householder_apply.sv
// Directed self-checking bench for householder_apply with hand-computed results.
module tb_householder_apply;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] h11 = 16'h0000, h12 = 16'h0000, h21 = 16'h0000, h22 = 16'h0000;
  logic [15:0] a11 = 16'h0000, a12 = 16'h0000, a21 = 16'h0000, a22 = 16'h0000;
  logic        busy, done;
  logic [15:0] r11, r12, r21, r22;

  int checks = 0;
  int failures = 0;

  householder_apply dut (
    .I_sys_clk (clk),
    .I_sys_rstn(rstn),
    .I_start   (start),
    .I_H1_h11  (h11),
    .I_H1_h12  (h12),
    .I_H1_h21  (h21),
    .I_H1_h22  (h22),
    .I_a11     (a11),
    .I_a12     (a12),
    .I_a21     (a21),
    .I_a22     (a22),
    .O_busy    (busy),
    .O_done    (done),
    .O_r11     (r11),
    .O_r12     (r12),
    .O_r21     (r21),
    .O_r22     (r22)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [15:0] p11, p12, p21, p22, q11, q12, q21, q22);
    h11 = p11; h12 = p12; h21 = p21; h22 = p22;
    a11 = q11; a12 = q12; a21 = q21; a22 = q22;
  endtask

  task automatic chk_r(input string tag, input logic [15:0] e11, e12, e21, e22);
    chk({tag, "_r11"}, {16'h0000, r11}, {16'h0000, e11});
    chk({tag, "_r12"}, {16'h0000, r12}, {16'h0000, e12});
    chk({tag, "_r21"}, {16'h0000, r21}, {16'h0000, e21});
    chk({tag, "_r22"}, {16'h0000, r22}, {16'h0000, e22});
  endtask

  // One start pulse with the current inputs; checks latency, busy span and result.
  task automatic run_job(input string tag, input logic [15:0] e11, e12, e21, e22);
    int lat;
    int busy_cnt;
    start = 1'b1;
    tick();            // E0
    start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    if (busy) busy_cnt++;
    chk({tag, "_latency"}, 32'(lat), 32'd9);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd10);
    chk_r(tag, e11, e12, e21, e22);
    tick();            // E10
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int ndone;
    int first_done;
    int second_done;

    // Reset, including a start that coincides with reset and must be dropped.
    rstn = 1'b0;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    rstn = 1'b1;
    tick();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk_r("reset", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    // Identity and diag(-1,1) reflectors.
    set_in(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0200, 16'h0080, 16'hFF80, 16'h0300);
    run_job("identity", 16'h0200, 16'h0080, 16'hFF80, 16'h0300);
    set_in(16'hFF00, 16'h0000, 16'h0000, 16'h0100, 16'h0200, 16'h0080, 16'hFF80, 16'h0300);
    run_job("reflect", 16'hFE00, 16'hFF80, 16'hFF80, 16'h0300);

    // Rounding boundaries.
    set_in(16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 16'h0000);
    run_job("round_up", 16'h0001, 16'h0000, 16'h0000, 16'h0000);
    set_in(16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h007F, 16'h0000, 16'h0000, 16'h0000);
    run_job("round_down", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    set_in(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 16'h0000);
    run_job("round_neg_half", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    // Saturation at both rails.
    set_in(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_job("sat_pos", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    set_in(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_job("sat_neg", 16'h8000, 16'h8000, 16'h8000, 16'h8000);

    // Start while busy is ignored; inputs changed after accept have no effect.
    set_in(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0200, 16'h0080, 16'hFF80, 16'h0300);
    start = 1'b1;
    tick();            // E0
    start = 1'b0;
    tick(); tick(); tick();
    set_in(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    start = 1'b1;
    tick();            // E4
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("busy_start_no_early_done", {31'd0, done}, 32'd0);
    tick();            // E9
    chk("busy_start_done_e9", {31'd0, done}, 32'd1);
    chk_r("busy_start", 16'h0200, 16'h0080, 16'hFF80, 16'h0300);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("busy_start_no_second_done", 32'(ndone), 32'd0);

    // Continuous start: done every 10 cycles.
    start = 1'b1;
    first_done = -1;
    second_done = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) begin
        if (first_done < 0) first_done = i;
        else if (second_done < 0) second_done = i;
      end
    end
    start = 1'b0;
    chk("cont_first_seen", {31'd0, first_done >= 0}, 32'd1);
    chk("cont_period", 32'(second_done - first_done), 32'd10);
    for (int i = 0; i < 12 && busy; i++) tick();
    tick();

    // Reset mid-operation after a job left R non-zero.
    chk("pre_reset_r11_nonzero", {31'd0, r11 != 16'h0000}, 32'd1);
    set_in(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0200, 16'h0080, 16'hFF80, 16'h0300);
    start = 1'b1;
    tick();            // E0
    start = 1'b0;
    tick(); tick(); tick(); tick();
    rstn = 1'b0;
    tick();            // E5
    rstn = 1'b1;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    chk_r("midreset", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("midreset_no_done", 32'(ndone), 32'd0);
    run_job("after_reset", 16'h0200, 16'h0080, 16'hFF80, 16'h0300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
